mpu_clock_gate: RTL and testbench

//   Consumer end of the free-running 1 MHz MPU clock from the 50 MHz divider. Tracks that

---
 rtl/mpu_clock_gate_pkg.sv | 14 +
 rtl/mpu_clock_gate_edge_detect.sv | 32 +++
 rtl/mpu_clock_gate.sv | 168 ++++++++++++++++
 tb/tb_mpu_clock_gate.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mpu_clock_gate_pkg.sv
// Shared definitions for the MPU clock path: FSM state encoding and the
// divider phase length, so the divider and the gate agree on timing.
package mpu_clock_gate_pkg;

    // clk cycles per mpu_clk phase (50 MHz / 1 MHz / 2)
    localparam int MPU_HALF_PERIOD = 25;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2
    } gate_state_t;

endpackage

// File: rtl/mpu_clock_gate_edge_detect.sv
// Rise/fall pulse generator: registers the previous level of a signal that is
// already synchronous to clk and flags 0->1 / 1->0 transitions in the cycle
// the new level is presented.
module mpu_clock_gate_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_d;
    logic sig_q;

    // Next history value is simply the current input level
    always_comb begin
        sig_d = sig_i;
    end

    // History register for the monitored signal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/mpu_clock_gate.sv
// Gated phi2 generator for the 6502. Follows the free-running divided clock
// one clk late while running or single-stepping, parks phi2 HIGH when
// stopped, and provides edge/sample strobes plus a rising-edge counter.
module mpu_clock_gate
    import mpu_clock_gate_pkg::*;
#(
    parameter int HALF_PERIOD = MPU_HALF_PERIOD,
    parameter int SAMPLE_DLY  = 20,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mpu_clk_in,
    input  logic             run_en,
    input  logic             step_press,
    output logic             phi2_out,
    output logic             phi2_rise,
    output logic             phi2_fall,
    output logic             sample_stb,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int TW = $clog2(HALF_PERIOD + 1);

    logic in_rise_s;
    logic in_fall_s;
    logic step_rise_s;
    logic step_fall_unused_s;

    gate_state_t      state_d, state_q;
    logic             phi2_d, phi2_q;
    logic             rise_d, rise_q;
    logic             fall_d, fall_q;
    logic             stb_d, stb_q;
    logic             running_d, running_q;
    logic             step_pend_d, step_pend_q;
    logic [TW-1:0]    timer_d, timer_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    mpu_clock_gate_edge_detect u_clk_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (mpu_clk_in),
        .rise_o (in_rise_s),
        .fall_o (in_fall_s)
    );

    mpu_clock_gate_edge_detect u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (step_press),
        .rise_o (step_rise_s),
        .fall_o (step_fall_unused_s)
    );

    // FSM next state and gated clock level; transitions only on input clock edges
    always_comb begin
        state_d = state_q;
        phi2_d  = phi2_q;
        case (state_q)
            ST_STOPPED: begin
                phi2_d = 1'b1;
                if (in_fall_s) begin
                    if (run_en) begin
                        state_d = ST_RUN;
                        phi2_d  = 1'b0;
                    end else if (step_pend_q) begin
                        state_d = ST_STEP;
                        phi2_d  = 1'b0;
                    end else begin
                        state_d = ST_STOPPED;
                    end
                end else begin
                    state_d = ST_STOPPED;
                end
            end
            ST_RUN: begin
                // the stopping rise still propagates so phi2 parks high
                phi2_d = mpu_clk_in;
                if (in_rise_s && !run_en) begin
                    state_d = ST_STOPPED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                // one low phase plus the closing rise, then park
                phi2_d = mpu_clk_in;
                if (in_rise_s) begin
                    state_d = ST_STOPPED;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_STOPPED;
                phi2_d  = 1'b1;
            end
        endcase
    end

    // Step request latch: armed only while stopped, consumed on entering STEP
    always_comb begin
        step_pend_d = step_pend_q;
        if ((state_d == ST_STEP) && (state_q != ST_STEP)) begin
            step_pend_d = 1'b0;
        end else if ((state_q == ST_STOPPED) && step_rise_s) begin
            step_pend_d = 1'b1;
        end else begin
            step_pend_d = step_pend_q;
        end
    end

    // Edge strobes, sample timer, cycle counter and running flag
    always_comb begin
        rise_d    = phi2_d & ~phi2_q;
        fall_d    = ~phi2_d & phi2_q;
        running_d = (state_d == ST_RUN);
        stb_d     = 1'b0;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        if (rise_d) begin
            timer_d = {TW{1'b0}};
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            stb_d = (timer_q == TW'(SAMPLE_DLY - 1));
            if (timer_q < TW'(SAMPLE_DLY)) begin
                timer_d = timer_q + TW'(1);
            end else begin
                timer_d = timer_q;
            end
        end
    end

    // State and output registers; reset parks phi2 high with the timer saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOPPED;
            phi2_q      <= 1'b1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            stb_q       <= 1'b0;
            running_q   <= 1'b0;
            step_pend_q <= 1'b0;
            timer_q     <= TW'(SAMPLE_DLY);
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            phi2_q      <= phi2_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            stb_q       <= stb_d;
            running_q   <= running_d;
            step_pend_q <= step_pend_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
        end
    end

    assign phi2_out   = phi2_q;
    assign phi2_rise  = rise_q;
    assign phi2_fall  = fall_q;
    assign sample_stb = stb_q;
    assign running    = running_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_mpu_clock_gate.sv
// Directed bench for mpu_clock_gate: a table of timed segments with hand
// computed end-of-segment values, per-cycle tracking/strobe checks, and
// hand-written reset and counter-wrap sequences.
module tb_mpu_clock_gate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mpu_clk_in = 1'b1;
    logic        run_en = 1'b0;
    logic        step_press = 1'b0;

    logic        phi2_out, phi2_rise, phi2_fall, sample_stb, running;
    logic [31:0] cycle_cnt;

    logic        w_unused_phi2, w_unused_rise, w_unused_fall, w_unused_stb, w_unused_run;
    logic [3:0]  cnt_w;

    mpu_clock_gate dut (
        .clk(clk), .rst(rst), .mpu_clk_in(mpu_clk_in), .run_en(run_en),
        .step_press(step_press), .phi2_out(phi2_out), .phi2_rise(phi2_rise),
        .phi2_fall(phi2_fall), .sample_stb(sample_stb), .running(running),
        .cycle_cnt(cycle_cnt)
    );

    mpu_clock_gate #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .mpu_clk_in(mpu_clk_in), .run_en(run_en),
        .step_press(step_press), .phi2_out(w_unused_phi2), .phi2_rise(w_unused_rise),
        .phi2_fall(w_unused_fall), .sample_stb(w_unused_stb), .running(w_unused_run),
        .cycle_cnt(cnt_w)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        run_en;
        logic        step;
        logic        hold;
        logic        follow;
        int          ncyc;
        logic        phi2;
        logic        run;
        logic [31:0] cnt;
        int          r;
        int          f;
        int          s;
    } vec_t;

    vec_t tbl[$];

    int   checks = 0;
    int   failures = 0;
    int   t = 0;
    int   ph = 0;
    int   last_rise = 0;
    bit   have_rise = 1'b0;
    bit   hold = 1'b1;
    bit   follow = 1'b0;
    logic prev_m = 1'b1;
    int   seg_r = 0;
    int   seg_f = 0;
    int   seg_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    function automatic logic gen_m(input int p);
        return ((p % 50) < 25) ? 1'b1 : 1'b0;
    endfunction

    // one clk: present the divided clock, sample #1 after the edge, run per-cycle checks
    task automatic cyc();
        logic exp_stb;
        if (!hold) begin
            mpu_clk_in = gen_m(ph);
            ph++;
        end
        prev_m = mpu_clk_in;
        @(posedge clk);
        #1;
        t++;
        exp_stb = have_rise && (t == last_rise + 20);
        chk("sample_stb_timing", 32'(sample_stb), 32'(exp_stb));
        if (phi2_rise && phi2_fall) begin
            chk("rise_fall_exclusive", 32'(phi2_rise & phi2_fall), 32'd0);
        end
        if (follow) begin
            chk("phi2_follows", 32'(phi2_out), 32'(prev_m));
        end
        if (phi2_rise) begin
            last_rise = t;
            have_rise = 1'b1;
            seg_r++;
        end
        if (phi2_fall) seg_f++;
        if (sample_stb) seg_s++;
    endtask

    task automatic add(input logic re, input logic st, input logic hd, input logic fo,
                       input int n, input logic p, input logic rn, input int c,
                       input int r, input int f, input int s);
        vec_t v;
        v.run_en = re; v.step = st; v.hold = hd; v.follow = fo; v.ncyc = n;
        v.phi2 = p; v.run = rn; v.cnt = 32'(c); v.r = r; v.f = f; v.s = s;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        // run, step, hold, follow, ncyc, phi2, running, cnt, rises, falls, samples
        add(1'b1, 1'b0, 1'b0, 1'b0,  25, 1'b1, 1'b0,  0,  0,  0,  0); // ends just before first in_fall reaches phi2
        add(1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b1,  0,  0,  1,  0); // first phi2_fall 1 clk after in_fall
        add(1'b1, 1'b0, 1'b0, 1'b1, 500, 1'b0, 1'b1, 10, 10, 10, 10); // 10 us of run
        add(1'b0, 1'b0, 1'b0, 1'b1,  24, 1'b0, 1'b1, 10,  0,  0,  0); // run_en dropped mid-low phase
        add(1'b0, 1'b0, 1'b0, 1'b1,   1, 1'b1, 1'b0, 11,  1,  0,  0); // stopping rise propagates
        add(1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b1, 1'b0, 11,  0,  0,  1); // parked high, strobe for final rise
        add(1'b0, 1'b1, 1'b0, 1'b0,   5, 1'b1, 1'b0, 11,  0,  0,  0); // step press while stopped
        add(1'b0, 1'b0, 1'b0, 1'b0,  19, 1'b1, 1'b0, 11,  0,  0,  0);
        add(1'b0, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b0, 11,  0,  1,  0); // step starts on in_fall
        add(1'b0, 1'b1, 1'b0, 1'b1,   3, 1'b0, 1'b0, 11,  0,  0,  0); // press during STEP
        add(1'b0, 1'b0, 1'b0, 1'b1,   3, 1'b0, 1'b0, 11,  0,  0,  0);
        add(1'b0, 1'b1, 1'b0, 1'b1,   3, 1'b0, 1'b0, 11,  0,  0,  0); // press during STEP
        add(1'b0, 1'b0, 1'b0, 1'b1,   3, 1'b0, 1'b0, 11,  0,  0,  0);
        add(1'b0, 1'b1, 1'b0, 1'b1,   3, 1'b0, 1'b0, 11,  0,  0,  0); // press during STEP
        add(1'b0, 1'b0, 1'b0, 1'b1,   9, 1'b0, 1'b0, 11,  0,  0,  0);
        add(1'b0, 1'b0, 1'b0, 1'b1,   1, 1'b1, 1'b0, 12,  1,  0,  0); // step completes with its rise
        add(1'b0, 1'b0, 1'b0, 1'b0, 100, 1'b1, 1'b0, 12,  0,  0,  1); // extra presses not queued
        add(1'b1, 1'b0, 1'b0, 1'b0,  25, 1'b0, 1'b1, 12,  0,  1,  0); // resume run
        add(1'b1, 1'b0, 1'b1, 1'b1, 200, 1'b0, 1'b1, 12,  0,  0,  0); // input clock frozen low
        add(1'b1, 1'b0, 1'b0, 1'b1,  25, 1'b1, 1'b1, 13,  1,  0,  0); // clock resumes
        add(1'b1, 1'b0, 1'b0, 1'b1,  25, 1'b0, 1'b1, 13,  0,  1,  1); // into a low phase in RUN

        // reset state
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_phi2", 32'(phi2_out), 32'd1);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        chk("rst_cnt_w", 32'(cnt_w), 32'd0);
        chk("rst_rise", 32'(phi2_rise), 32'd0);
        chk("rst_fall", 32'(phi2_fall), 32'd0);
        chk("rst_stb", 32'(sample_stb), 32'd0);

        rst = 1'b0;
        t = 0;
        ph = 0;
        hold = 1'b0;

        foreach (tbl[i]) begin
            run_en = tbl[i].run_en;
            step_press = tbl[i].step;
            hold = tbl[i].hold;
            follow = tbl[i].follow;
            seg_r = 0; seg_f = 0; seg_s = 0;
            for (int c = 0; c < tbl[i].ncyc; c++) cyc();
            chk($sformatf("seg%0d_phi2", i), 32'(phi2_out), 32'(tbl[i].phi2));
            chk($sformatf("seg%0d_running", i), 32'(running), 32'(tbl[i].run));
            chk($sformatf("seg%0d_cnt", i), cycle_cnt, tbl[i].cnt);
            chk($sformatf("seg%0d_cnt_w", i), 32'(cnt_w), tbl[i].cnt & 32'hF);
            chk($sformatf("seg%0d_rises", i), 32'(seg_r), 32'(tbl[i].r));
            chk($sformatf("seg%0d_falls", i), 32'(seg_f), 32'(tbl[i].f));
            chk($sformatf("seg%0d_samples", i), 32'(seg_s), 32'(tbl[i].s));
        end

        // asynchronous reset while phi2 is low in RUN
        follow = 1'b0;
        chk("pre_rst_phi2_low", 32'(phi2_out), 32'd0);
        #3;
        rst = 1'b1;
        have_rise = 1'b0;
        #1;
        chk("async_rst_phi2", 32'(phi2_out), 32'd1);
        chk("async_rst_cnt", cycle_cnt, 32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        chk("async_rst_fall", 32'(phi2_fall), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        ph = 0;
        run_en = 1'b1;
        step_press = 1'b0;

        // counter wrap on the 4-bit instance: 15 rises, then one more
        seg_r = 0;
        n = 0;
        while (seg_r < 15 && n < 2000) begin
            cyc();
            n++;
        end
        chk("wrap_pre_rises", 32'(seg_r), 32'd15);
        chk("wrap_pre_cnt", cycle_cnt, 32'd15);
        chk("wrap_pre_cnt_w", 32'(cnt_w), 32'd15);
        n = 0;
        while (seg_r < 16 && n < 100) begin
            cyc();
            n++;
        end
        chk("wrap_rise_seen", 32'(seg_r), 32'd16);
        chk("wrap_cnt", cycle_cnt, 32'd16);
        chk("wrap_cnt_w", 32'(cnt_w), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
